// File: rtl/stack_master.sv
// Initiator for the 4-bit stack bus: one request in flight, occupancy tracking.
// Optional refusal of illegal operations is enabled with `define STACK_MASTER_GUARD_EN.
module stack_master #(
  parameter int unsigned DEPTH = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [3:0] REQ_DATA,
  input  logic [2:0] REQ_INDEX,
  output logic       RSP_VALID,
  output logic [3:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [2:0] COUNT,
  inout  wire  [3:0] IO_DATA,
  output logic [1:0] COMMAND,
  output logic [2:0] INDEX
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_GET = 2'b11} op_e;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] data_q, data_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;
  logic [3:0] rdata_q, rdata_d;
  logic [3:0] cap_q;
  logic       refuse;
  logic       accept;

  assign accept = REQ_VALID && REQ_READY;

  always_comb begin
    refuse = 1'b0;
`ifdef STACK_MASTER_GUARD_EN
    case (op_e'(REQ_OP))
      OP_PUSH: refuse = (count_q == DEPTH_C);
      OP_POP:  refuse = (count_q == 3'd0);
      OP_GET:  refuse = (REQ_INDEX >= count_q);
      default: refuse = 1'b0;
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    idx_d   = idx_q;
    count_d = count_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_e'(REQ_OP);
          data_d  = REQ_DATA;
          idx_d   = REQ_INDEX;
          err_d   = refuse;
          rdata_d = '0;
          if (refuse || op_e'(REQ_OP) == OP_NOP) state_d = S_RESP;
          else                                   state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_q == OP_PUSH && count_q != DEPTH_C) count_d = count_q + 3'd1;
        if (op_q == OP_POP && count_q != 3'd0)     count_d = count_q - 3'd1;
        state_d = (op_q == OP_PUSH) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        rdata_d = cap_q;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stack drives read data during WAIT's high phase; sample it mid-cycle.
  always_ff @(negedge CLK) begin
    if (state_q == S_WAIT) cap_q <= IO_DATA;
  end

  assign REQ_READY = (state_q == S_IDLE) && !RESET;
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_DATA  = RSP_VALID ? rdata_q : '0;
  assign RSP_ERR   = RSP_VALID && err_q;
  assign COUNT     = count_q;
  assign COMMAND   = (state_q == S_ISSUE) ? op_q : OP_NOP;
  assign INDEX     = (state_q == S_ISSUE && op_q == OP_GET) ? idx_q : '0;
  assign IO_DATA   = (state_q == S_ISSUE && op_q == OP_PUSH) ? data_q : 4'bzzzz;

endmodule

// File: tb/tb_stack_master.sv
// Directed bench for stack_master with a behavioural 5-entry stack on the bus.
module tb_stack_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_data;
  logic [2:0] req_index;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] count;
  wire  [3:0] io_data;
  logic [1:0] command;
  logic [2:0] index;

  int checks = 0;
  int failures = 0;

  stack_master #(.DEPTH(5)) dut (
    .CLK(clk), .RESET(reset),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_OP(req_op), .REQ_DATA(req_data), .REQ_INDEX(req_index),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .COUNT(count), .IO_DATA(io_data), .COMMAND(command), .INDEX(index)
  );

  always #5 clk = ~clk;

  // Behavioural stack: samples the bus at the edge ending ISSUE, answers during WAIT.
  logic [3:0] mem [5];
  int         sp;
  logic       drv_en;
  logic [3:0] drv;
  assign io_data = drv_en ? drv : 4'bzzzz;

  always @(posedge clk) begin
    if (reset) begin
      sp = 0;
      drv_en <= 1'b0;
      drv <= 4'h0;
    end else begin
      drv_en <= 1'b0;
      case (command)
        2'b01: if (sp < 5) begin mem[sp] = io_data; sp = sp + 1; end
        2'b10: begin
          drv_en <= 1'b1;
          if (sp > 0) begin drv <= mem[sp-1]; sp = sp - 1; end
          else drv <= 4'h0;
        end
        2'b11: begin
          drv_en <= 1'b1;
          drv <= (int'(index) < sp) ? mem[sp-1-int'(index)] : 4'h0;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] idx;
    int         lat;
    logic [3:0] rdata;
    logic       err;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic do_req(input vec_t v, input int n);
    int lat = 0;
    int cmd_seen = 0;
    int idx_seen = 0;
    int bus_seen = -1;
    int stray_idx = 0;
    int got_data = -1;
    int got_err = -1;
    int got_cnt = -1;
    int exp_cmd;
    @(negedge clk);
    chk($sformatf("v%0d ready", n), int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    req_index = v.idx;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 4'h0;
    req_index = 3'd0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (command != 2'b00) begin
        cmd_seen = int'(command);
        idx_seen = int'(index);
        if (command == 2'b01) bus_seen = int'(io_data);
      end else if (index != 3'd0) stray_idx = 1;
      if (rsp_valid) begin
        lat = cyc;
        got_data = int'(rsp_data);
        got_err = int'(rsp_err);
        got_cnt = int'(count);
        break;
      end
      @(posedge clk); #1;
    end
    exp_cmd = (v.lat == 1) ? 0 : int'(v.op);
    chk($sformatf("v%0d latency", n), lat, v.lat);
    chk($sformatf("v%0d rsp_data", n), got_data, int'(v.rdata));
    chk($sformatf("v%0d rsp_err", n), got_err, int'(v.err));
    chk($sformatf("v%0d count", n), got_cnt, int'(v.cnt));
    chk($sformatf("v%0d bus_cmd", n), cmd_seen, exp_cmd);
    chk($sformatf("v%0d bus_index", n), idx_seen, (exp_cmd == 3) ? int'(v.idx) : 0);
    chk($sformatf("v%0d stray_index", n), stray_idx, 0);
    if (exp_cmd == 1) chk($sformatf("v%0d bus_push_data", n), bus_seen, int'(v.data));
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_pulse", n), int'(rsp_valid), 0);
  endtask

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;
`ifdef STACK_MASTER_GUARD_EN
  localparam int    RL = 1;
  localparam logic  RE = 1'b1;
`else
  localparam int    RL = 3;
  localparam logic  RE = 1'b0;
`endif

  initial begin
    tbl.push_back('{PUSH, 4'h3, 3'd0, 2, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{PUSH, 4'hA, 3'd0, 2, 4'h0, 1'b0, 3'd2});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'hA, 1'b0, 3'd1});
    tbl.push_back('{NOP,  4'h0, 3'd0, 1, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'h3, 1'b0, 3'd0});
    tbl.push_back('{PUSH, 4'h1, 3'd0, 2, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{PUSH, 4'h2, 3'd0, 2, 4'h0, 1'b0, 3'd2});
    tbl.push_back('{PUSH, 4'h3, 3'd0, 2, 4'h0, 1'b0, 3'd3});
    tbl.push_back('{GET,  4'h0, 3'd2, 3, 4'h1, 1'b0, 3'd3});
    tbl.push_back('{GET,  4'h0, 3'd0, 3, 4'h3, 1'b0, 3'd3});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'h3, 1'b0, 3'd2});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'h2, 1'b0, 3'd1});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'h1, 1'b0, 3'd0});
    // Empty-stack boundary: refused with the guard, forwarded without it.
    tbl.push_back('{POP,  4'h0, 3'd0, RL, 4'h0, RE, 3'd0});
    tbl.push_back('{GET,  4'h0, 3'd0, RL, 4'h0, RE, 3'd0});
    tbl.push_back('{PUSH, 4'h4, 3'd0, 2, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{PUSH, 4'h5, 3'd0, 2, 4'h0, 1'b0, 3'd2});
    tbl.push_back('{PUSH, 4'h6, 3'd0, 2, 4'h0, 1'b0, 3'd3});
    tbl.push_back('{PUSH, 4'h7, 3'd0, 2, 4'h0, 1'b0, 3'd4});
    tbl.push_back('{PUSH, 4'h8, 3'd0, 2, 4'h0, 1'b0, 3'd5});
`ifdef STACK_MASTER_GUARD_EN
    tbl.push_back('{PUSH, 4'h9, 3'd0, 1, 4'h0, 1'b1, 3'd5});
`else
    tbl.push_back('{PUSH, 4'h9, 3'd0, 2, 4'h0, 1'b0, 3'd5});
`endif
    tbl.push_back('{GET,  4'h0, 3'd4, 3, 4'h4, 1'b0, 3'd5});
    tbl.push_back('{GET,  4'h0, 3'd5, RL, 4'h0, RE, 3'd5});
    tbl.push_back('{POP,  4'h0, 3'd0, 3, 4'h8, 1'b0, 3'd4});

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_data = 4'h0;
    req_index = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst ready", int'(req_ready), 0);
    chk("rst rsp_valid", int'(rsp_valid), 0);
    chk("rst rsp_data", int'(rsp_data), 0);
    chk("rst rsp_err", int'(rsp_err), 0);
    chk("rst count", int'(count), 0);
    chk("rst command", int'(command), 0);
    chk("rst index", int'(index), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready", int'(req_ready), 1);
    chk("post-rst rsp_valid", int'(rsp_valid), 0);

    foreach (tbl[i]) do_req(tbl[i], i);

    // Reset arriving while a POP waits for read data aborts it silently.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = POP;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = NOP;
    chk("abort issue cmd", int'(command), int'(POP));
    @(posedge clk); #1;
    chk("abort wait cmd", int'(command), 0);
    chk("abort wait count", int'(count), 3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort rsp_valid", int'(rsp_valid), 0);
    chk("abort count", int'(count), 0);
    chk("abort command", int'(command), 0);
    chk("abort ready", int'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen = 1;
      end
      chk("abort no response", seen, 0);
    end
    chk("abort idle ready", int'(req_ready), 1);
    do_req('{POP, 4'h0, 3'd0, RL, 4'h0, RE, 3'd0}, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
